vedic_pp_stage: RTL and testbench

VEDIC_PP_STAGE -- requirements
Module: vedic_pp_stage

---
 rtl/vedic_pp_stage_pkg.sv | 6 +
 rtl/vedic_pp_stage_vedic4x4.sv | 62 ++++++
 rtl/vedic_pp_stage.sv | 77 +++++++
 tb/tb_vedic_pp_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pp_stage_pkg.sv
// Shared widths for the Vedic partial-product pipeline stage.
package vedic_pp_stage_pkg;
  localparam int OP_W  = 8;
  localparam int NIB_W = 4;
  localparam int PP_W  = 8;
endpackage

// File: rtl/vedic_pp_stage_vedic4x4.sv
// Adder cells and a 4x4 unsigned Urdhva-Tiryakbhyam multiplier, purely combinational.
// Crosswise terms of each column are compressed with full/half adders; carries ripple left.
module HalfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module FullAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module vedic4x4
  import vedic_pp_stage_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic [PP_W-1:0]  p
);
  // row[j][i] is the vertical/crosswise term a[i]*b[j]
  logic [NIB_W-1:0] row [NIB_W];
  always_comb begin
    for (int j = 0; j < NIB_W; j++) row[j] = a & {NIB_W{b[j]}};
  end

  logic c1a, s2a, c2a, c2b;
  logic s3a, c3a, s3b, c3b, c3c;
  logic s4a, c4a, s4b, c4b, c4c;
  logic s5a, c5a, c5b, c6;

  assign p[0] = row[0][0];
  HalfAdder u_h1  (.a(row[0][1]), .b(row[1][0]), .s(p[1]), .c(c1a));

  FullAdder u_f2a (.a(row[0][2]), .b(row[1][1]), .ci(row[2][0]), .s(s2a), .co(c2a));
  HalfAdder u_h2  (.a(s2a), .b(c1a), .s(p[2]), .c(c2b));

  FullAdder u_f3a (.a(row[0][3]), .b(row[1][2]), .ci(row[2][1]), .s(s3a), .co(c3a));
  FullAdder u_f3b (.a(row[3][0]), .b(c2a), .ci(c2b), .s(s3b), .co(c3b));
  HalfAdder u_h3  (.a(s3a), .b(s3b), .s(p[3]), .c(c3c));

  FullAdder u_f4a (.a(row[1][3]), .b(row[2][2]), .ci(row[3][1]), .s(s4a), .co(c4a));
  FullAdder u_f4b (.a(c3a), .b(c3b), .ci(c3c), .s(s4b), .co(c4b));
  HalfAdder u_h4  (.a(s4a), .b(s4b), .s(p[4]), .c(c4c));

  FullAdder u_f5a (.a(row[2][3]), .b(row[3][2]), .ci(c4a), .s(s5a), .co(c5a));
  FullAdder u_f5b (.a(s5a), .b(c4b), .ci(c4c), .s(p[5]), .co(c5b));

  // 15*15 fits in 8 bits, so the column-6 carry is the final product bit
  FullAdder u_f6  (.a(row[3][3]), .b(c5a), .ci(c5b), .s(p[6]), .co(c6));
  assign p[7] = c6;
endmodule

// File: rtl/vedic_pp_stage.sv
// Two-register pipeline producing the four nibble partial products of an 8x8 multiply.
// Latency 2 cycles; valid/ready with combinational ready chain, bubbles fill under stall.
module vedic_pp_stage
  import vedic_pp_stage_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PP_W-1:0]  pp_ll,
  output logic [PP_W-1:0]  pp_hl,
  output logic [PP_W-1:0]  pp_lh,
  output logic [PP_W-1:0]  pp_hh,
  output logic [CNT_W-1:0] tx_count
);
  logic            s1_valid;
  logic [OP_W-1:0] s1_a;
  logic [OP_W-1:0] s1_b;
  logic            s2_valid;
  logic            s2_ready;
  logic            in_xfer;
  logic            s1_adv;
  logic            out_xfer;
  logic [PP_W-1:0] ll_c, hl_c, lh_c, hh_c;

  assign s2_ready  = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign in_xfer   = in_valid && in_ready;
  assign s1_adv    = s1_valid && s2_ready;
  assign out_valid = s2_valid;
  assign out_xfer  = s2_valid && out_ready;

  vedic4x4 u_ll (.a(s1_a[NIB_W-1:0]),    .b(s1_b[NIB_W-1:0]),    .p(ll_c));
  vedic4x4 u_hl (.a(s1_a[OP_W-1:NIB_W]), .b(s1_b[NIB_W-1:0]),    .p(hl_c));
  vedic4x4 u_lh (.a(s1_a[NIB_W-1:0]),    .b(s1_b[OP_W-1:NIB_W]), .p(lh_c));
  vedic4x4 u_hh (.a(s1_a[OP_W-1:NIB_W]), .b(s1_b[OP_W-1:NIB_W]), .p(hh_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_xfer) begin
        s1_a <= in_a;
        s1_b <= in_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      pp_ll    <= '0;
      pp_hl    <= '0;
      pp_lh    <= '0;
      pp_hh    <= '0;
      tx_count <= '0;
    end else begin
      if (s2_ready) s2_valid <= s1_valid;
      if (s1_adv) begin
        pp_ll <= ll_c;
        pp_hl <= hl_c;
        pp_lh <= lh_c;
        pp_hh <= hh_c;
      end
      if (out_xfer) tx_count <= tx_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_vedic_pp_stage.sv
// Randomized and directed bench for vedic_pp_stage with a queue scoreboard.
module tb_vedic_pp_stage;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] pp_ll, pp_hl, pp_lh, pp_hh;
  logic [7:0] tx_count;

  vedic_pp_stage #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .pp_ll(pp_ll), .pp_hl(pp_hl), .pp_lh(pp_lh), .pp_hh(pp_hh),
    .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pps;
    logic [15:0] prod;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] model_cnt = '0;
  int         xfers = 0;
  int         cyc = 0;
  int         first_cyc = 0;
  int         last_cyc = 0;
  bit         stall_prev = 0;
  logic [31:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur within bound (t=%0t)", name, $time);
  endtask

  // Reference: nibble products by plain arithmetic, full product as a*b
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int al, ah, bl, bh;
    al = int'(a) % 16; ah = int'(a) / 16;
    bl = int'(b) % 16; bh = int'(b) / 16;
    e.pps  = {8'(al * bl), 8'(ah * bl), 8'(al * bh), 8'(ah * bh)};
    e.prod = 16'(int'(a) * int'(b));
    return e;
  endfunction

  function automatic logic [15:0] recombine(input logic [7:0] ll, hl, lh, hh);
    return ({8'd0, hh} << 8) + (({8'd0, hl} + {8'd0, lh}) << 4) + {8'd0, ll};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard push on input transfer, monitor pop on output transfer
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hold", {pp_ll, pp_hl, pp_lh, pp_hh}, held);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: output 0x%0h with empty scoreboard", {pp_ll, pp_hl, pp_lh, pp_hh});
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pp", {pp_ll, pp_hl, pp_lh, pp_hh}, e.pps);
          chk("recomb", {16'd0, recombine(pp_ll, pp_hl, pp_lh, pp_hh)}, {16'd0, e.prod});
        end
        chk("tx_count", {24'd0, tx_count}, {24'd0, model_cnt});
        model_cnt = model_cnt + 8'd1;
        if (xfers == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfers++;
      end
      stall_prev = out_valid && !out_ready;
      held = {pp_ll, pp_hl, pp_lh, pp_hh};
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b));
    end else begin
      stall_prev = 0;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit ok = 0;
    int n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
      if (!ok && n > 500) begin
        fail_now("send_timeout");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sb.delete();
    model_cnt = '0;
    xfers = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_tx_count", {24'd0, tx_count}, 0);
    chk("rst_pp", {pp_ll, pp_hl, pp_lh, pp_hh}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    do_reset();
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);

    // 0xFF*0xFF, two-cycle latency
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", {31'd0, out_valid}, 0);
    @(negedge clk);
    chk("lat_valid", {31'd0, out_valid}, 1);
    chk("pp_e1", {pp_ll, pp_hl, pp_lh, pp_hh}, 32'hE1E1E1E1);
    @(negedge clk);
    chk("tx_after_one", {24'd0, tx_count}, 1);

    // Worked example
    send(8'h3C, 8'hA5);
    repeat (2) @(negedge clk);
    chk("ex_pp", {pp_ll, pp_hl, pp_lh, pp_hh}, 32'h3C0F781E);
    chk("ex_prod", {16'd0, recombine(pp_ll, pp_hl, pp_lh, pp_hh)}, 32'h26AC);
    drain();

    // Back-to-back stream
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), 8'h11);
    repeat (4) @(posedge clk);
    #1;
    chk("stream_count", xfers, 16);
    chk("stream_b2b", last_cyc - first_cyc, 15);
    chk("stream_tx", {24'd0, tx_count}, 16);

    // Stall with a full pipe, then release
    out_ready = 1'b0;
    send(8'h12, 8'h34);
    send(8'h56, 8'h78);
    in_a = 8'h9A; in_b = 8'hBC; in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h9A, 8'hBC);
    drain();
    chk("stall_tx", {24'd0, tx_count}, 19);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    send(8'hAA, 8'h55);
    send(8'h0F, 8'hF0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_tx", {24'd0, tx_count}, 0);
    chk("arst_in_ready", {31'd0, in_ready}, 1);
    sb.delete();
    model_cnt = '0;
    xfers = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("arst_no_old_xfer", xfers, 0);

    // Counter wrap
    for (int i = 0; i < 255; i++) send(8'($urandom), 8'($urandom));
    repeat (3) @(posedge clk);
    #1;
    chk("pre_wrap", {24'd0, tx_count}, 255);
    send(8'h01, 8'h02);
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_zero", {24'd0, tx_count}, 0);

    // Random valid/ready traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
